// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store engine.
// Holds the instruction ID constants used by decoder/EX/MEM, the FSM state
// encoding, the access size type and small decode helpers.
package mem_access_unit_pkg;

    // Instruction IDs of the memory operations (shared with decoder/EX).
    localparam logic [5:0] INSTR_LB  = 6'd20;
    localparam logic [5:0] INSTR_LH  = 6'd21;
    localparam logic [5:0] INSTR_LW  = 6'd22;
    localparam logic [5:0] INSTR_LBU = 6'd23;
    localparam logic [5:0] INSTR_LHU = 6'd24;
    localparam logic [5:0] INSTR_SB  = 6'd25;
    localparam logic [5:0] INSTR_SH  = 6'd26;
    localparam logic [5:0] INSTR_SW  = 6'd27;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    function automatic logic is_mem_op(input logic [5:0] id);
        return id inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU,
                          INSTR_LHU, INSTR_SB, INSTR_SH, INSTR_SW};
    endfunction

    function automatic logic is_store_op(input logic [5:0] id);
        return id inside {INSTR_SB, INSTR_SH, INSTR_SW};
    endfunction

    function automatic logic is_signed_load(input logic [5:0] id);
        return id inside {INSTR_LB, INSTR_LH};
    endfunction

    function automatic mem_size_e op_size(input logic [5:0] id);
        mem_size_e sz;
        case (id)
            INSTR_LB, INSTR_LBU, INSTR_SB: sz = SZ_BYTE;
            INSTR_LH, INSTR_LHU, INSTR_SH: sz = SZ_HALF;
            default:                       sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering.
//   st_size/st_off/st_data -> st_wdata (lane-replicated), st_wstrb
//   ld_size/ld_off/ld_signed/ld_word -> ld_data (extracted and extended)
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_size_e   st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  mem_size_e   ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic [31:0]        ld_shifted;
    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_size)
            SZ_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            SZ_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << st_off;
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign ld_shifted = ld_word >> {ld_off, 3'b000};
    assign ld_byte    = ld_shifted[7:0];
    assign ld_half    = ld_shifted[15:0];

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SZ_BYTE: ld_data = ld_signed ? {{24{ld_byte[7]}}, ld_byte}
                                         : {24'd0, ld_byte};
            SZ_HALF: ld_data = ld_signed ? {{16{ld_half[15]}}, ld_half}
                                         : {16'd0, ld_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine.
// Takes the registered EX/MEM instruction, runs one req/ack transaction on the
// data-memory port, stalls the pipeline while it is in flight and returns the
// aligned, extended load result to writeback.
//   inputs : valid_in, instr_id_in, mem_addr_in, store_data_in, rd_addr_in,
//            rd_valid_in, dmem_ack, dmem_rdata
//   outputs: stall_out (comb), dmem_req/we/addr/wdata/wstrb, load_data_out,
//            wb_valid_out, wb_rd_out, misaligned_out, bus_error_out
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [5:0]        instr_id_in,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [31:0]       store_data_in,
    input  logic [4:0]        rd_addr_in,
    input  logic              rd_valid_in,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [31:0]       load_data_out,
    output logic              wb_valid_out,
    output logic [4:0]        wb_rd_out,
    output logic              misaligned_out,
    output logic              bus_error_out
);
    localparam int CNT_W = 16;

    state_e           state, state_nxt;
    logic [CNT_W-1:0] timeout_cnt;

    mem_size_e   in_size, size_q;
    logic        in_mem, in_store, in_aligned;
    logic        start, misalign, ack_hit, timeout_hit;
    logic [1:0]  off_q;
    logic        signed_q, wb_en_q;
    logic [4:0]  rd_q;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

    assign in_mem   = is_mem_op(instr_id_in);
    assign in_store = is_store_op(instr_id_in);
    assign in_size  = op_size(instr_id_in);

    always_comb begin
        case (in_size)
            SZ_HALF: in_aligned = ~mem_addr_in[0];
            SZ_WORD: in_aligned = (mem_addr_in[1:0] == 2'b00);
            default: in_aligned = 1'b1;
        endcase
    end

    // valid_in is only looked at in IDLE: in DONE it still shows the
    // instruction that just completed.
    assign start    = (state == IDLE) & valid_in & in_mem & in_aligned;
    assign misalign = (state == IDLE) & valid_in & in_mem & ~in_aligned;
    assign stall_out = start | (state == WAIT);

    // Ack has priority over the timeout when both land in the same cycle.
    assign ack_hit     = (state == WAIT) & dmem_ack;
    assign timeout_hit = (state == WAIT) & ~dmem_ack & (TIMEOUT_CYCLES != 0)
                       & (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    mem_lane_align u_align (
        .st_size   (in_size),
        .st_off    (mem_addr_in[1:0]),
        .st_data   (store_data_in),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_size   (size_q),
        .ld_off    (off_q),
        .ld_signed (signed_q),
        .ld_word   (dmem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (ack_hit || timeout_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_cnt    <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            load_data_out  <= '0;
            wb_valid_out   <= 1'b0;
            wb_rd_out      <= '0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            size_q         <= SZ_WORD;
            off_q          <= '0;
            signed_q       <= 1'b0;
            wb_en_q        <= 1'b0;
            rd_q           <= '0;
        end else begin
            misaligned_out <= misalign;
            wb_valid_out   <= 1'b0;
            bus_error_out  <= 1'b0;
            if (start) begin
                timeout_cnt <= '0;
                dmem_req    <= 1'b1;
                dmem_we     <= in_store;
                dmem_addr   <= {mem_addr_in[ADDR_W-1:2], 2'b00};
                dmem_wdata  <= st_wdata;
                dmem_wstrb  <= in_store ? st_wstrb : 4'b0000;
                size_q      <= in_size;
                off_q       <= mem_addr_in[1:0];
                signed_q    <= is_signed_load(instr_id_in);
                wb_en_q     <= ~in_store & rd_valid_in & (rd_addr_in != 5'd0);
                rd_q        <= rd_addr_in;
            end
            if (ack_hit) begin
                dmem_req   <= 1'b0;
                dmem_we    <= 1'b0;
                dmem_wstrb <= 4'b0000;
                if (!dmem_we) begin
                    load_data_out <= ld_data;
                    wb_valid_out  <= wb_en_q;
                    wb_rd_out     <= rd_q;
                end
            end else if (timeout_hit) begin
                dmem_req      <= 1'b0;
                dmem_we       <= 1'b0;
                dmem_wstrb    <= 4'b0000;
                load_data_out <= '0;
                bus_error_out <= 1'b1;
            end else if (state == WAIT) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
// Directed vector table applied in a loop, plus hand-written sequences for
// reset state, reset during WAIT and stray acks.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [5:0]  instr_id_in;
    logic [31:0] mem_addr_in;
    logic [31:0] store_data_in;
    logic [4:0]  rd_addr_in;
    logic        rd_valid_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_out;
    logic        wb_valid_out;
    logic [4:0]  wb_rd_out;
    logic        misaligned_out;
    logic        bus_error_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .instr_id_in(instr_id_in),
        .mem_addr_in(mem_addr_in), .store_data_in(store_data_in),
        .rd_addr_in(rd_addr_in), .rd_valid_in(rd_valid_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .load_data_out(load_data_out), .wb_valid_out(wb_valid_out),
        .wb_rd_out(wb_rd_out), .misaligned_out(misaligned_out),
        .bus_error_out(bus_error_out)
    );

    typedef struct {
        string       name;
        logic [5:0]  id;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rdv;
        int          ack_dly;   // WAIT cycles before ack; large = never
        logic [31:0] rdata;
        logic        exp_start;
        logic        exp_mis;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_wb;
        logic [31:0] exp_load;
        logic        exp_bus;
        int          exp_waits;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; instr_id_in = 6'd0; mem_addr_in = '0;
        store_data_in = '0; rd_addr_in = '0; rd_valid_in = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int waits;
        int stalls;
        @(negedge clk);
        valid_in = 1'b1; instr_id_in = v.id; mem_addr_in = v.addr;
        store_data_in = v.sdata; rd_addr_in = v.rd; rd_valid_in = v.rdv;
        dmem_ack = 1'b0; dmem_rdata = v.rdata;
        #1;
        chk({v.name, ".stall_detect"}, 32'(stall_out), 32'(v.exp_start));
        if (!v.exp_start) begin
            @(posedge clk); #1;
            chk({v.name, ".misaligned"}, 32'(misaligned_out), 32'(v.exp_mis));
            chk({v.name, ".no_req"}, 32'(dmem_req), 32'd0);
            chk({v.name, ".no_stall"}, 32'(stall_out), 32'd0);
            idle_inputs();
            @(posedge clk); #1;
            chk({v.name, ".mis_pulse_end"}, 32'(misaligned_out), 32'd0);
            chk({v.name, ".load_hold"}, load_data_out, v.exp_load);
            return;
        end
        stalls = 1;
        @(posedge clk); #1;
        chk({v.name, ".req"}, 32'(dmem_req), 32'd1);
        chk({v.name, ".we"}, 32'(dmem_we), 32'(v.exp_we));
        chk({v.name, ".addr"}, dmem_addr, v.exp_addr);
        chk({v.name, ".wstrb"}, 32'(dmem_wstrb), 32'(v.exp_wstrb));
        if (v.exp_we) chk({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
        waits = 0;
        while (dmem_req) begin
            stalls += int'(stall_out);
            dmem_ack = (waits == v.ack_dly);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            waits++;
            if (waits > 20) begin
                chk({v.name, ".req_never_dropped"}, 32'(dmem_req), 32'd0);
                break;
            end
        end
        // DONE cycle
        chk({v.name, ".waits"}, 32'(waits), 32'(v.exp_waits));
        chk({v.name, ".stall_cycles"}, 32'(stalls), 32'(v.exp_waits + 1));
        chk({v.name, ".stall_done"}, 32'(stall_out), 32'd0);
        chk({v.name, ".wb_valid"}, 32'(wb_valid_out), 32'(v.exp_wb));
        chk({v.name, ".bus_error"}, 32'(bus_error_out), 32'(v.exp_bus));
        chk({v.name, ".load_data"}, load_data_out, v.exp_load);
        if (v.exp_wb) chk({v.name, ".wb_rd"}, 32'(wb_rd_out), 32'(v.rd));
        // Pipeline advances after DONE; valid_in still high during DONE.
        idle_inputs();
        @(posedge clk); #1;
        chk({v.name, ".wb_pulse_end"}, 32'(wb_valid_out), 32'd0);
        chk({v.name, ".bus_pulse_end"}, 32'(bus_error_out), 32'd0);
        chk({v.name, ".idle_req"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        //          name     id         addr          sdata         rd  rdv dly rdata         st mis we addr          wdata         strb     wb load          bus waits
        vecs[0]  = '{"lw",    INSTR_LW,  32'h100, 32'h0,        5'd5, 1, 0,  32'hDEADBEEF, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 1, 32'hDEADBEEF, 0, 1};
        vecs[1]  = '{"lb",    INSTR_LB,  32'h103, 32'h0,        5'd6, 1, 0,  32'h80FF1234, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 1, 32'hFFFFFF80, 0, 1};
        vecs[2]  = '{"lbu",   INSTR_LBU, 32'h103, 32'h0,        5'd7, 1, 0,  32'h80FF1234, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 1, 32'h00000080, 0, 1};
        vecs[3]  = '{"lh",    INSTR_LH,  32'h102, 32'h0,        5'd8, 1, 0,  32'h80FF1234, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 1, 32'hFFFF80FF, 0, 1};
        vecs[4]  = '{"lhu",   INSTR_LHU, 32'h102, 32'h0,        5'd9, 1, 0,  32'h80FF1234, 1, 0, 0, 32'h100, 32'h0,        4'b0000, 1, 32'h000080FF, 0, 1};
        vecs[5]  = '{"sb",    INSTR_SB,  32'h201, 32'h000000AB, 5'd0, 0, 0,  32'h0,        1, 0, 1, 32'h200, 32'hABABABAB, 4'b0010, 0, 32'h000080FF, 0, 1};
        vecs[6]  = '{"sh",    INSTR_SH,  32'h202, 32'h1234CDEF, 5'd0, 0, 1,  32'h0,        1, 0, 1, 32'h200, 32'hCDEFCDEF, 4'b1100, 0, 32'h000080FF, 0, 2};
        vecs[7]  = '{"sw",    INSTR_SW,  32'h300, 32'hCAFEF00D, 5'd0, 0, 0,  32'h0,        1, 0, 1, 32'h300, 32'hCAFEF00D, 4'b1111, 0, 32'h000080FF, 0, 1};
        vecs[8]  = '{"lh_mis",INSTR_LH,  32'h101, 32'h0,        5'd3, 1, 0,  32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 0, 32'h000080FF, 0, 0};
        vecs[9]  = '{"lw_mis",INSTR_LW,  32'h102, 32'h0,        5'd3, 1, 0,  32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 0, 32'h000080FF, 0, 0};
        vecs[10] = '{"nonmem",6'd0,      32'h100, 32'h0,        5'd3, 1, 0,  32'h0,        0, 0, 0, 32'h0,   32'h0,        4'b0000, 0, 32'h000080FF, 0, 0};
        vecs[11] = '{"lw_w2", INSTR_LW,  32'h104, 32'h0,        5'd10,1, 2,  32'h12345678, 1, 0, 0, 32'h104, 32'h0,        4'b0000, 1, 32'h12345678, 0, 3};
        vecs[12] = '{"lw_w3", INSTR_LW,  32'h108, 32'h0,        5'd11,1, 3,  32'hA5A55A5A, 1, 0, 0, 32'h108, 32'h0,        4'b0000, 1, 32'hA5A55A5A, 0, 4};
        vecs[13] = '{"lw_to", INSTR_LW,  32'h10C, 32'h0,        5'd12,1, 99, 32'h11111111, 1, 0, 0, 32'h10C, 32'h0,        4'b0000, 0, 32'h00000000, 1, 4};
        vecs[14] = '{"lw_rd0",INSTR_LW,  32'h110, 32'h0,        5'd0, 1, 0,  32'h0BADF00D, 1, 0, 0, 32'h110, 32'h0,        4'b0000, 0, 32'h0BADF00D, 0, 1};
        vecs[15] = '{"sw_mis",INSTR_SW,  32'h301, 32'h0,        5'd0, 0, 0,  32'h0,        0, 1, 0, 32'h0,   32'h0,        4'b0000, 0, 32'h0BADF00D, 0, 0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.stall", 32'(stall_out), 32'd0);
        chk("rst.wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst.load", load_data_out, 32'd0);
        chk("rst.wb", 32'(wb_valid_out), 32'd0);
        chk("rst.bus", 32'(bus_error_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Stray ack while idle must be ignored.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("stray_ack.wb", 32'(wb_valid_out), 32'd0);
        chk("stray_ack.load", load_data_out, 32'h0BADF00D);
        chk("stray_ack.stall", 32'(stall_out), 32'd0);

        // Reset after two WAIT cycles without ack.
        @(negedge clk);
        valid_in = 1'b1; instr_id_in = INSTR_LW; mem_addr_in = 32'h100;
        rd_addr_in = 5'd4; rd_valid_in = 1'b1;
        @(posedge clk); #1;
        chk("rstwait.req1", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        chk("rstwait.req2", 32'(dmem_req), 32'd1);
        rst = 1'b1; valid_in = 1'b0;
        @(posedge clk); #1;
        chk("rstwait.req", 32'(dmem_req), 32'd0);
        chk("rstwait.stall", 32'(stall_out), 32'd0);
        chk("rstwait.wb", 32'(wb_valid_out), 32'd0);
        chk("rstwait.bus", 32'(bus_error_out), 32'd0);
        chk("rstwait.mis", 32'(misaligned_out), 32'd0);
        idle_inputs();
        rst = 1'b0;
        run_vec('{"sw_after_rst", INSTR_SW, 32'h300, 32'h01020304, 5'd0, 0, 0, 32'h0,
                  1, 0, 1, 32'h300, 32'h01020304, 4'b1111, 0, 32'h0, 0, 1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
